// File: rtl/interrupt_controller_if.sv
// Data-memory port between the core (master) and the interrupt controller (slave).
interface interrupt_controller_if;
    logic [15:0] busAddr;
    logic [1:0]  busControl;
    logic [15:0] busWriteData;
    logic [15:0] busReadData;
    logic        busHit;

    modport master (
        output busAddr, busControl, busWriteData,
        input  busReadData, busHit
    );

    modport slave (
        input  busAddr, busControl, busWriteData,
        output busReadData, busHit
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronizes 16 asynchronous request lines, latches their
// rising edges into PENDING, masks them with MASK and presents the lowest-numbered
// enabled request to the core as a one-cycle pulse plus index.
module interrupt_controller #(
    parameter logic [15:0] BASE_ADDR = 16'hBF10,
    parameter int unsigned HOLDOFF   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           irqLines,
    interrupt_controller_if.slave bus,
    output logic                  hardwareInterruptSignal,
    output logic [3:0]            hardwareInterruptIndex
);
    localparam logic [15:0]   MASK_ADDR   = BASE_ADDR + 16'd1;
    localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + 16'd2;
    localparam int unsigned   CW          = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLDOFF - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_SERVICE, ST_HOLDOFF} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [15:0]   sync1, sync2, sync3;
    logic [15:0]   pending, mask;

    logic          is_load, is_store;
    logic [15:0]   w1c, rise, pending_next, cand;
    logic [3:0]    winner;
    logic          in_service;
    logic [15:0]   status;

    // Lowest set bit index wins; an empty vector yields 0 (never used then).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Bus decode, W1C mask, edge detect and next PENDING value.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        is_load      = (bus.busControl == 2'b01);
        is_store     = (bus.busControl == 2'b10);
        w1c          = (is_store && bus.busAddr == BASE_ADDR) ? bus.busWriteData : 16'h0000;
        rise         = sync2 & ~sync3;
        // A rising edge on the same edge as a W1C of that bit keeps the bit set.
        pending_next = (pending & ~w1c) | rise;
        cand         = pending & mask;
        winner       = lowest_set(cand);
        in_service   = (state == ST_SERVICE);
        status       = {in_service, 11'b0, hardwareInterruptIndex};
    end

    // Synchronizer chain, PENDING and MASK registers.
    // NOTE: non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 16'h0000;
            sync2   <= 16'h0000;
            sync3   <= 16'h0000;
            pending <= 16'h0000;
            mask    <= 16'h0000;
        end else begin
            sync1   <= irqLines;
            sync2   <= sync1;
            sync3   <= sync2;
            pending <= pending_next;
            if (is_store && bus.busAddr == MASK_ADDR) mask <= bus.busWriteData;
        end
    end

    // Registered load response: data and hit valid the cycle after the load is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busReadData <= 16'h0000;
            bus.busHit      <= 1'b0;
        end else begin
            bus.busReadData <= 16'h0000;
            bus.busHit      <= 1'b0;
            if (is_load) begin
                case (bus.busAddr)
                    BASE_ADDR: begin
                        bus.busReadData <= pending;
                        bus.busHit      <= 1'b1;
                    end
                    MASK_ADDR: begin
                        bus.busReadData <= mask;
                        bus.busHit      <= 1'b1;
                    end
                    STATUS_ADDR: begin
                        bus.busReadData <= status;
                        bus.busHit      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Request sequencer: pick, pulse, wait for the handler's W1C, then hold off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= ST_IDLE;
            hold_cnt                <= '0;
            hardwareInterruptSignal <= 1'b0;
            hardwareInterruptIndex  <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cand != 16'h0000) begin
                        state                   <= ST_PULSE;
                        hardwareInterruptSignal <= 1'b1;
                        hardwareInterruptIndex  <= winner;
                    end
                end
                ST_PULSE: begin
                    hardwareInterruptSignal <= 1'b0;
                    state                   <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    // Service ends on the edge that clears the bit; no pre-emption.
                    if (!pending_next[hardwareInterruptIndex]) begin
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_HOLDOFF;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == '0) state <= ST_IDLE;
                    else                hold_cnt <= hold_cnt - CW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a cycle-level reference model
// built from register/timing rules, a per-cycle compare process, directed
// scenarios with literal expectations, then randomized traffic.
module tb_interrupt_controller;
    localparam logic [15:0] BASE   = 16'hBF10;
    localparam logic [15:0] M_ADDR = 16'hBF11;
    localparam logic [15:0] S_ADDR = 16'hBF12;
    localparam logic [15:0] X_ADDR = 16'hBF13;
    localparam int          HOLD   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq;
    logic        sig;
    logic [3:0]  idx;

    interrupt_controller_if bus_if();

    interrupt_controller #(.BASE_ADDR(BASE), .HOLDOFF(HOLD)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .irqLines                (irq),
        .bus                     (bus_if),
        .hardwareInterruptSignal (sig),
        .hardwareInterruptIndex  (idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is counted in edges; after edge e the design is "in cycle e".
    logic [15:0] m_pend = '0, m_mask = '0, m_rdata = '0;
    logic [15:0] m_h1 = '0, m_h2 = '0, m_h3 = '0;  // irq samples 1, 2, 3 edges ago
    logic        m_hit = 1'b0, m_pulse = 1'b0, m_serv = 1'b0;
    logic [3:0]  m_idx = '0;
    int          m_cyc = 0;
    int          m_idle_from = -16;                 // first cycle a new pick may be seen idle
    logic [15:0] t_rise, t_w1c, t_pnew, t_cand;
    logic        t_ld, t_st;

    function automatic logic [3:0] first_one(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; m_mask = '0; m_rdata = '0; m_hit = 0;
            m_h1 = '0; m_h2 = '0; m_h3 = '0;
            m_pulse = 0; m_serv = 0; m_idx = '0; m_idle_from = -16;
        end else begin
            m_cyc++;
            // Line sampled high 2 edges ago and low 3 edges ago -> PENDING set now.
            t_rise = m_h2 & ~m_h3;
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq;
            t_ld   = (bus_if.busControl == 2'b01);
            t_st   = (bus_if.busControl == 2'b10);
            t_w1c  = (t_st && bus_if.busAddr == BASE) ? bus_if.busWriteData : 16'h0;
            t_pnew = (m_pend & ~t_w1c) | t_rise;
            t_cand = m_pend & m_mask;
            m_rdata = 16'h0; m_hit = 0;
            if (t_ld) begin
                if (bus_if.busAddr == BASE)        begin m_hit = 1; m_rdata = m_pend; end
                else if (bus_if.busAddr == M_ADDR) begin m_hit = 1; m_rdata = m_mask; end
                else if (bus_if.busAddr == S_ADDR) begin m_hit = 1; m_rdata = {m_serv, 11'b0, m_idx}; end
            end
            if (m_pulse) begin
                m_pulse = 0; m_serv = 1;
            end else if (m_serv) begin
                if (!t_pnew[m_idx]) begin
                    m_serv = 0;
                    m_idle_from = m_cyc + HOLD;
                end
            end else if (m_cyc - 1 >= m_idle_from && t_cand != 16'h0) begin
                m_pulse = 1;
                m_idx = first_one(t_cand);
            end
            m_pend = t_pnew;
            if (t_st && bus_if.busAddr == M_ADDR) m_mask = bus_if.busWriteData;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pulse", {15'b0, sig}, {15'b0, m_pulse});
        check("index", {12'b0, idx}, {12'b0, m_idx});
        check("rdata", bus_if.busReadData, m_rdata);
        check("hit", {15'b0, bus_if.busHit}, {15'b0, m_hit});
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.busControl   = 2'b00;
        bus_if.busAddr      = 16'h0000;
        bus_if.busWriteData = 16'h0000;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        bus_if.busControl = 2'b10; bus_if.busAddr = a; bus_if.busWriteData = d;
        tick();
        bus_idle();
    endtask

    task automatic load(input logic [15:0] a, output logic [15:0] d, output logic h);
        bus_if.busControl = 2'b01; bus_if.busAddr = a; bus_if.busWriteData = 16'h0;
        tick();
        bus_idle();
        @(negedge clk);
        d = bus_if.busReadData;
        h = bus_if.busHit;
        tick();
    endtask

    task automatic wait_pulse(input string name, input int limit, input logic [3:0] exp_idx,
                              output int waited);
        waited = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (sig === 1'b1) begin
                waited = n;
                break;
            end
        end
        if (waited < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no pulse expected pulse within %0d cycles", name, limit);
        end else begin
            check(name, {12'b0, idx}, {12'b0, exp_idx});
        end
        tick();
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (sig === 1'b1) cnt++;
        end
        tick();
    endtask

    // ---------------- test sequence ----------------
    logic [15:0] rd;
    logic        rh;
    int          w, cnt, r, b;

    initial begin
        rst = 1'b0;
        irq = 16'h0;
        bus_idle();
        repeat (3) tick();
        @(negedge clk);
        check("reset_sig",   {15'b0, sig}, 16'h0);
        check("reset_index", {12'b0, idx}, 16'h0);
        check("reset_rdata", bus_if.busReadData, 16'h0);
        check("reset_hit",   {15'b0, bus_if.busHit}, 16'h0);
        tick();
        rst = 1'b1;
        tick();

        // Single source, held level must not re-trigger after W1C.
        store(M_ADDR, 16'h0008);
        irq[3] = 1'b1;
        wait_pulse("single_pulse", 8, 4'h3, w);
        @(negedge clk);
        check("single_pulse_width", {15'b0, sig}, 16'h0);
        tick();
        load(S_ADDR, rd, rh);
        check("single_status_busy", rd, 16'h8003);
        check("single_status_hit", {15'b0, rh}, 16'h0001);
        store(BASE, 16'h0008);
        load(S_ADDR, rd, rh);
        check("single_status_done", rd, 16'h0003);
        count_pulses(12, cnt);
        check("single_no_repeat", 16'(cnt), 16'h0);
        irq[3] = 1'b0;

        // Priority: lowest index first, next one after the holdoff gap.
        store(M_ADDR, 16'hFFFF);
        irq[9] = 1'b1;
        irq[2] = 1'b1;
        wait_pulse("prio_first", 10, 4'h2, w);
        store(BASE, 16'h0004);
        wait_pulse("prio_second", 10, 4'h9, w);
        check("prio_holdoff_gap", 16'(w), 16'd6);
        store(BASE, 16'h0200);
        irq = 16'h0;
        repeat (8) tick();

        // Masking: pending latches while disabled, pulse once enabled.
        store(M_ADDR, 16'h0000);
        irq[5] = 1'b1;
        count_pulses(8, cnt);
        check("mask_no_pulse", 16'(cnt), 16'h0);
        load(BASE, rd, rh);
        check("mask_pending", rd, 16'h0020);
        store(M_ADDR, 16'h0020);
        wait_pulse("mask_enable", 2, 4'h5, w);
        store(BASE, 16'h0020);
        irq[5] = 1'b0;
        repeat (8) tick();

        // Set wins over a same-edge W1C.
        irq[1] = 1'b1;
        tick();
        tick();
        store(BASE, 16'h0002);
        load(BASE, rd, rh);
        check("collision_set_wins", rd, 16'h0002);
        store(BASE, 16'h0002);
        load(BASE, rd, rh);
        check("collision_cleared", rd, 16'h0000);
        irq[1] = 1'b0;

        // Decode: unmapped address neither answers nor writes.
        load(X_ADDR, rd, rh);
        check("decode_rdata", rd, 16'h0000);
        check("decode_hit", {15'b0, rh}, 16'h0000);
        store(X_ADDR, 16'hFFFF);
        load(M_ADDR, rd, rh);
        check("decode_mask_kept", rd, 16'h0020);
        load(BASE, rd, rh);
        check("decode_pending_kept", rd, 16'h0000);
        load(S_ADDR, rd, rh);
        check("decode_status_kept", rd, 16'h0005);

        // Reset in the middle of a service.
        store(M_ADDR, 16'hFFFF);
        irq[0] = 1'b1;
        irq[2] = 1'b1;
        wait_pulse("rst_pulse", 10, 4'h0, w);
        load(BASE, rd, rh);
        check("rst_pending_before", rd, 16'h0005);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_sig",   {15'b0, sig}, 16'h0);
        check("rst_mid_index", {12'b0, idx}, 16'h0);
        check("rst_mid_rdata", bus_if.busReadData, 16'h0);
        check("rst_mid_hit",   {15'b0, bus_if.busHit}, 16'h0);
        irq = 16'h0;
        tick();
        tick();
        rst = 1'b1;
        load(BASE, rd, rh);
        check("rst_pending_after", rd, 16'h0000);
        load(M_ADDR, rd, rh);
        check("rst_mask_after", rd, 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 15);
                irq[b] = ~irq[b];
            end
            r = $urandom_range(0, 9);
            bus_idle();
            case (r)
                4: begin
                    bus_if.busControl   = 2'b10;
                    bus_if.busAddr      = BASE;
                    bus_if.busWriteData = ($urandom_range(0, 1) == 1) ? (m_pend & 16'($urandom))
                                                                       : 16'($urandom);
                end
                5: begin
                    bus_if.busControl   = 2'b10;
                    bus_if.busAddr      = M_ADDR;
                    bus_if.busWriteData = 16'($urandom) | 16'($urandom);
                end
                6, 7: begin
                    bus_if.busControl = 2'b01;
                    bus_if.busAddr    = BASE + 16'($urandom_range(0, 3));
                end
                8: begin
                    bus_if.busControl   = 2'b11;
                    bus_if.busAddr      = BASE + 16'($urandom_range(0, 3));
                    bus_if.busWriteData = 16'($urandom);
                end
                9: begin
                    bus_if.busControl   = 2'($urandom);
                    bus_if.busAddr      = 16'($urandom);
                    bus_if.busWriteData = 16'($urandom);
                end
                default: ;
            endcase
            if (i == 2000) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        bus_idle();
        irq = 16'h0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
